// File: rtl/hamming31_serial_decoder.sv
// Serial Hamming(31,26) decoder fed by a 5-bit frame counter: one code bit per cycle,
// syndrome accumulated on the fly, single-error correction registered on the fim cycle.
module hamming31_serial_decoder #(
   parameter int CODE_LEN = 31,
   parameter int DATA_LEN = 26,
   parameter int CNT_W    = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bit_in,
   input  logic                bit_valid,
   input  logic [CNT_W-1:0]    count,
   input  logic                fim,
   output logic [DATA_LEN-1:0] data_out,
   output logic                data_valid,
   output logic                err_corrected,
   output logic [4:0]          syndrome,
   output logic                frame_abort
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CODE_LEN);

   logic [CODE_LEN:1]   code_q;
   logic [CNT_W-1:0]    syn_acc;
   logic                in_frame;

   logic [CNT_W-1:0]    pos;
   logic                sample;
   logic                abort_hit;
   logic                close;
   logic [CODE_LEN:0]   flip_mask;
   logic [CODE_LEN:1]   fixed;
   logic [DATA_LEN-1:0] data_fix;

   always_comb begin
      pos       = count + CNT_W'(1);
      sample    = bit_valid && !fim && (count != LAST);
      abort_hit = in_frame && !bit_valid && !fim && (count != '0) && (count != LAST);
      close     = fim && in_frame;
      // A zero syndrome lands on bit 0 of the mask, which is dropped, so no flip happens.
      flip_mask = (CODE_LEN+1)'(1) << syn_acc;
      fixed     = code_q ^ flip_mask[CODE_LEN:1];
      // Data positions are every non-power-of-two position, ascending from p3.
      data_fix  = {fixed[31:17], fixed[15:9], fixed[7:5], fixed[3]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q        <= '0;
         syn_acc       <= '0;
         in_frame      <= 1'b0;
         data_out      <= '0;
         data_valid    <= 1'b0;
         err_corrected <= 1'b0;
         syndrome      <= '0;
         frame_abort   <= 1'b0;
      end else begin
         data_valid    <= close;
         err_corrected <= close && (syn_acc != '0);
         frame_abort   <= abort_hit;
         if (close) begin
            data_out <= data_fix;
            syndrome <= syn_acc;
            in_frame <= 1'b0;
         end
         if (sample) begin
            code_q[pos] <= bit_in;
            if (count == '0) begin
               in_frame <= 1'b1;
               syn_acc  <= bit_in ? CNT_W'(1) : '0;
            end else begin
               syn_acc <= syn_acc ^ (bit_in ? pos : '0);
            end
         end else if (abort_hit) begin
            in_frame <= 1'b0;
            syn_acc  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hamming31_serial_decoder.sv
// Bench for hamming31_serial_decoder: models the upstream frame counter, encodes frames,
// and scores decoded words through a queue popped whenever data_valid is seen.
module tb_hamming31_serial_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        bit_in;
   logic        bit_valid;
   logic [4:0]  count;
   logic        fim;
   logic [25:0] data_out;
   logic        data_valid;
   logic        err_corrected;
   logic [4:0]  syndrome;
   logic        frame_abort;

   logic [4:0]  cnt;
   logic        ovr_en;
   logic [4:0]  ovr_val;

   int errors = 0;
   int checks = 0;
   int aborts_seen = 0;

   typedef struct {
      logic [25:0] data;
      logic [4:0]  syn;
      logic        err;
   } exp_t;

   typedef struct {
      logic [25:0] data;
      int          flip;
      logic [25:0] exp_data;
      logic [4:0]  exp_syn;
      logic        exp_err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[9];

   always #5 clk = ~clk;

   hamming31_serial_decoder dut (
      .clk           (clk),
      .rst           (rst),
      .bit_in        (bit_in),
      .bit_valid     (bit_valid),
      .count         (count),
      .fim           (fim),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .err_corrected (err_corrected),
      .syndrome      (syndrome),
      .frame_abort   (frame_abort)
   );

   // Upstream frame counter: bit_valid starts it, frame_abort restarts it, wraps after 31.
   always @(posedge clk or posedge rst) begin
      if (rst)                      cnt <= 5'd0;
      else if (frame_abort)         cnt <= 5'd0;
      else if (cnt != 5'd0 || bit_valid) cnt <= cnt + 5'd1;
   end

   assign count = ovr_en ? ovr_val : cnt;
   assign fim   = (count == 5'd31);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:1] encode(input logic [25:0] d);
      logic [31:1] w;
      logic        par;
      int          k;
      w = '0;
      k = 0;
      for (int p = 1; p <= 31; p++) begin
         if ((p & (p - 1)) != 0) begin
            w[p] = d[k];
            k++;
         end
      end
      for (int b = 0; b < 5; b++) begin
         par = 1'b0;
         for (int p = 1; p <= 31; p++)
            if (((p >> b) & 1) == 1) par ^= w[p];
         w[1 << b] = par;
      end
      return w;
   endfunction

   function automatic logic [31:1] make_cw(input logic [25:0] d, input int flip);
      logic [31:1] w;
      w = encode(d);
      if (flip != 0) w[flip] = ~w[flip];
      return w;
   endfunction

   always @(negedge clk) begin
      if (!rst && frame_abort) aborts_seen++;
      if (!rst && data_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_data_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("data_out", 32'(data_out), 32'(e.data));
            chk("syndrome", 32'(syndrome), 32'(e.syn));
            chk("err_corrected", 32'(err_corrected), 32'(e.err));
         end
      end
   end

   task automatic send_frame(input logic [31:1] w, input logic keep_valid,
                             input logic [25:0] ed, input logic [4:0] es, input logic ee);
      exp_t e;
      for (int i = 0; i < 31; i++) begin
         bit_valid = 1'b1;
         bit_in    = w[i+1];
         @(posedge clk); #1;
      end
      // fim cycle: bit_in must be ignored even if still flagged valid
      bit_valid = keep_valid;
      bit_in    = 1'b1;
      e.data = ed; e.syn = es; e.err = ee;
      sb.push_back(e);
      @(posedge clk); #1;
      chk("dv_pulse", 32'(data_valid), 32'd1);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      @(posedge clk); #1;
      chk("dv_clear", 32'(data_valid), 32'd0);
      chk("err_clear", 32'(err_corrected), 32'd0);
      chk("data_hold", 32'(data_out), 32'(ed));
      chk("syn_hold", 32'(syndrome), 32'(es));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:1] w;
      logic [25:0] rd;
      int          fl;

      vecs[0] = '{26'h0000000,  0, 26'h0000000, 5'd0,  1'b0};
      vecs[1] = '{26'h0000001,  0, 26'h0000001, 5'd0,  1'b0};
      vecs[2] = '{26'h0000001,  5, 26'h0000001, 5'd5,  1'b1};
      vecs[3] = '{26'h0000001,  1, 26'h0000001, 5'd1,  1'b1};
      vecs[4] = '{26'h3FFFFFF,  0, 26'h3FFFFFF, 5'd0,  1'b0};
      vecs[5] = '{26'h0000002,  0, 26'h0000002, 5'd0,  1'b0};
      vecs[6] = '{26'h2AAAAAA, 31, 26'h2AAAAAA, 5'd31, 1'b1};
      vecs[7] = '{26'h1555555, 16, 26'h1555555, 5'd16, 1'b1};
      vecs[8] = '{26'h0000000,  3, 26'h0000000, 5'd3,  1'b1};

      rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; ovr_en = 1'b0; ovr_val = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_err", 32'(err_corrected), 32'd0);
      chk("rst_syndrome", 32'(syndrome), 32'd0);
      chk("rst_abort", 32'(frame_abort), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 9; v++)
         send_frame(make_cw(vecs[v].data, vecs[v].flip), v[0],
                    vecs[v].exp_data, vecs[v].exp_syn, vecs[v].exp_err);

      // Stream breaks at count 10: abort pulse, counter restart, no output word.
      w = encode(26'h3FFFFFF);
      for (int i = 0; i < 10; i++) begin
         bit_valid = 1'b1; bit_in = w[i+1];
         @(posedge clk); #1;
      end
      bit_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_pulse", 32'(frame_abort), 32'd1);
      chk("abort_no_dv", 32'(data_valid), 32'd0);
      @(posedge clk); #1;
      chk("abort_single", 32'(frame_abort), 32'd0);
      chk("abort_cnt_zero", 32'(count), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      send_frame(encode(26'h3FFFFFF), 1'b0, 26'h3FFFFFF, 5'd0, 1'b0);
      send_frame(make_cw(26'h3FFFFFF, 7), 1'b0, 26'h3FFFFFF, 5'd7, 1'b1);

      // Reset lands mid-frame at count 15.
      w = encode(26'h1234567);
      for (int i = 0; i < 15; i++) begin
         bit_valid = 1'b1; bit_in = w[i+1];
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("mid_rst_data_out", 32'(data_out), 32'd0);
      chk("mid_rst_syndrome", 32'(syndrome), 32'd0);
      chk("mid_rst_dv", 32'(data_valid), 32'd0);
      chk("mid_rst_err", 32'(err_corrected), 32'd0);
      chk("mid_rst_abort", 32'(frame_abort), 32'd0);
      bit_valid = 1'b0; bit_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send_frame(31'h0000001A >> 1 << 1 == 0 ? '0 : make_cw(26'h0000002, 0), 1'b0,
                 26'h0000002, 5'd0, 1'b0);

      // fim seen without an open frame, then a gap at count 5 while idle.
      ovr_en = 1'b1; ovr_val = 5'd31;
      @(posedge clk); #1;
      ovr_val = 5'd5;
      chk("orphan_fim_no_dv", 32'(data_valid), 32'd0);
      chk("orphan_fim_no_abort", 32'(frame_abort), 32'd0);
      @(posedge clk); #1;
      ovr_en = 1'b0;
      chk("idle_gap_no_abort", 32'(frame_abort), 32'd0);
      chk("idle_gap_no_dv", 32'(data_valid), 32'd0);

      // Double error on p1 and p2 aliases to p3 and silently miscorrects data bit 0.
      w = encode(26'h0000000);
      w[1] = ~w[1];
      w[2] = ~w[2];
      send_frame(w, 1'b0, 26'h0000001, 5'd3, 1'b1);

      for (int n = 0; n < 20; n++) begin
         rd = 26'($urandom());
         fl = $urandom_range(0, 31);
         send_frame(make_cw(rd, fl), 1'($urandom_range(0, 1)), rd, 5'(fl), fl != 0);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      chk("abort_count", 32'(aborts_seen), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hamming31_serial_decoder.md
Name: hamming31_serial_decoder

Overview:
- Serial Hamming(31,26) single-error-correcting decoder, directly downstream of the 5-bit frame counter (val_max = 31).
- Samples one received code bit per cycle, indexed by the counter's `count`, and accumulates the syndrome on the fly.
- On the counter's frame-end cycle (`fim`), corrects any single-bit error and emits the 26 data bits.
- Drives `frame_abort` into the counter's `error_flag` to restart framing when the serial stream breaks mid-frame.

Parameters:
- CODE_LEN, 31, code bits per frame; only the default is supported.
- DATA_LEN, 26, data bits per frame (CODE_LEN minus 5 parity bits).
- CNT_W, 5, width of `count`; must equal $clog2(CODE_LEN+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  received serial code bit.
- bit_valid  input  1  `bit_in` valid this cycle; the same net drives the counter's `start`.
- count  input  CNT_W  frame counter value; code position = count+1.
- fim  input  1  counter frame-end flag (count == 31).
- data_out  output  DATA_LEN  corrected data word.
- data_valid  output  1  one-cycle pulse, `data_out` valid.
- err_corrected  output  1  qualified by `data_valid`; a nonzero syndrome was corrected.
- syndrome  output  5  qualified by `data_valid`; final syndrome of the frame.
- frame_abort  output  1  one-cycle pulse to the counter's `error_flag`.

Behaviour:
- Reset (async, rst=1): `data_out`=0, `data_valid`=0, `err_corrected`=0, `syndrome`=0, `frame_abort`=0. The internal 31-bit codeword register, the syndrome accumulator and `in_frame` all clear.
- Code definition:
  - Position p (1..31) has parity-check column equal to binary p.
  - Parity bits sit at p = 1, 2, 4, 8, 16.
  - Data bits fill the remaining positions in ascending order: p=3 → data bit 0, p=5 → bit 1, p=6 → bit 2, p=7 → bit 3, p=9 → bit 4, …, p=31 → bit 25.
- Sampling:
  - When bit_valid=1 and count ≤ 30: store bit_in at position count+1, and update `syn_acc ^= bit_in ? (count+1) : 0`.
  - On the first sample at count=0, `in_frame` is set to 1 and `syn_acc` is loaded fresh, not XORed.
- Frame close:
  - At the fim cycle (count=31), bit_in is ignored regardless of bit_valid.
  - If in_frame=1: compute the correction from syn_acc, register the outputs at that edge, and clear in_frame.
  - data_valid is high exactly during the cycle following the fim cycle; latency is 1 cycle after fim, 2 cycles after the last code bit.
- Correction:
  - syndrome≠0: flip position `syndrome`, set err_corrected=1.
  - syndrome=0: no flip, err_corrected=0.
  - A parity-position error sets err_corrected=1 with data unchanged.
  - Double errors are not detected; they miscorrect silently (by design).
- Hold behaviour: data_out and syndrome hold their values until the next data_valid. err_corrected clears with data_valid.
- Abort:
  - Trigger: in_frame=1, 1 ≤ count ≤ 30, and bit_valid=0.
  - Next edge: frame_abort=1 for one cycle, in_frame clears, syn_acc clears; no data_valid is issued.
  - The counter returns to 0 on the following edge.
  - bit_valid=0 while count=0 is idle, not an abort.
- fim with in_frame=0 (e.g. counter mis-sequenced): no data_valid, no abort.
- Reset mid-frame: partial frame discarded; the next frame starts fresh at count=0.

Test Plan:
- All-zero codeword, bit_valid high for 31 cycles → one cycle after fim: data_valid=1, data_out=26'h0, syndrome=0, err_corrected=0.
- Codeword with p1, p2, p3 set (others 0) → data_out=26'h0000001, syndrome=0, err_corrected=0.
- Same codeword with p5 flipped (bit at count=4) → syndrome=5, err_corrected=1, data_out=26'h0000001.
- Same codeword with p1 flipped (count=0) → syndrome=1, err_corrected=1, data_out=26'h0000001.
- bit_valid dropped at count=10 → frame_abort pulses one cycle, counter returns to 0, no data_valid. A following clean all-ones-data frame then decodes with data_out=26'h3FFFFFF and err_corrected=0.
- rst asserted at count=15 mid-frame → all outputs 0 immediately. The next frame (p5 set, p1 and p4 set) decodes to data_out=26'h0000002, syndrome=0.
